// File: rtl/ula_control_mc.sv
// ALU/MDU control for the RV32IM EX stage: decodes the ALU select code
// and sequences multi-cycle multiply/divide ops, stalling until done.
module ula_control_mc #(
  parameter int SEL_W    = 5,
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 34,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [9:0]       inst,
  input  logic [2:0]       ula_op,
  output logic [SEL_W-1:0] ula_select,
  output logic             illegal,
  output logic             mdu_start,
  output logic             mdu_is_div,
  output logic             stall,
  output logic             mdu_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] C_ADD   = SEL_W'(1);
  localparam logic [SEL_W-1:0] C_SUB   = SEL_W'(2);
  localparam logic [SEL_W-1:0] C_SLL   = SEL_W'(3);
  localparam logic [SEL_W-1:0] C_SLT   = SEL_W'(4);
  localparam logic [SEL_W-1:0] C_SLTU  = SEL_W'(5);
  localparam logic [SEL_W-1:0] C_SRL   = SEL_W'(6);
  localparam logic [SEL_W-1:0] C_SRA   = SEL_W'(7);
  localparam logic [SEL_W-1:0] C_XOR   = SEL_W'(8);
  localparam logic [SEL_W-1:0] C_OR    = SEL_W'(9);
  localparam logic [SEL_W-1:0] C_AND   = SEL_W'(10);
  localparam logic [SEL_W-1:0] C_LUI   = SEL_W'(11);
  localparam logic [SEL_W-1:0] C_AUIPC = SEL_W'(12);
  localparam logic [SEL_W-1:0] C_MUL   = SEL_W'(13);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_ill;
  logic             dec_m;
  logic             dec_div;
  logic             trig;
  logic             one_cyc;

  logic [6:0] f7;
  logic [2:0] f3;

  assign f7 = inst[9:3];
  assign f3 = inst[2:0];

  function automatic logic [SEL_W-1:0] base_op(input logic [2:0] f);
    logic [SEL_W-1:0] r;
    unique case (f)
      3'b000:  r = C_ADD;
      3'b001:  r = C_SLL;
      3'b010:  r = C_SLT;
      3'b011:  r = C_SLTU;
      3'b100:  r = C_XOR;
      3'b101:  r = C_SRL;
      3'b110:  r = C_OR;
      default: r = C_AND;
    endcase
    return r;
  endfunction

  always_comb begin
    dec_sel = '0;
    dec_ill = 1'b0;
    dec_m   = 1'b0;
    unique case (ula_op)
      3'b000: dec_sel = C_ADD;
      3'b001: begin
        unique case (f3[2:1])
          2'b10:   dec_sel = C_SLT;
          2'b11:   dec_sel = C_SLTU;
          default: dec_sel = C_SUB;
        endcase
      end
      3'b010: begin
        if (f7 == 7'b0000000) begin
          dec_sel = base_op(f3);
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec_sel = C_SUB;
          else if (f3 == 3'b101) dec_sel = C_SRA;
          else                   dec_ill = 1'b1;
        end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
          dec_m   = 1'b1;
          dec_sel = C_MUL + SEL_W'(f3);
        end else begin
          dec_ill = 1'b1;
        end
      end
      3'b011: begin
        unique case (f3)
          3'b001: begin
            if (f7 == 7'b0000000) dec_sel = C_SLL;
            else                  dec_ill = 1'b1;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      dec_sel = C_SRL;
            else if (f7 == 7'b0100000) dec_sel = C_SRA;
            else                       dec_ill = 1'b1;
          end
          default: dec_sel = base_op(f3);
        endcase
      end
      3'b100:  dec_sel = C_LUI;
      3'b101:  dec_sel = C_AUIPC;
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_div = dec_m & f3[2];
  assign one_cyc = dec_div ? (DIV_LAT == 1) : (MUL_LAT == 1);
  assign trig    = valid_in & ~flush & ~reset & dec_m & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          sel_d   = dec_sel;
          div_d   = dec_div;
          cnt_d   = dec_div ? DIV_CNT : MUL_CNT;
          state_d = one_cyc ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ula_select = '0;
    illegal    = 1'b0;
    stall      = 1'b0;
    mdu_start  = 1'b0;
    mdu_is_div = 1'b0;
    unique case (state_q)
      IDLE: begin
        ula_select = dec_sel;
        illegal    = valid_in & dec_ill;
        stall      = trig;
        mdu_start  = trig;
        mdu_is_div = trig & dec_div;
      end
      BUSY: begin
        ula_select = sel_q;
        stall      = ~flush;
        mdu_is_div = div_q;
      end
      DONE: begin
        ula_select = sel_q;
        mdu_is_div = div_q;
      end
      default: ;
    endcase
    // Reset wins over everything that could launch or hold the pipe.
    if (reset) begin
      ula_select = '0;
      illegal    = 1'b0;
      stall      = 1'b0;
      mdu_start  = 1'b0;
    end
  end

  assign mdu_done = (state_q == DONE) & ~flush & ~reset;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ula_control_mc.sv
// Directed bench for ula_control_mc: decode table plus
// multi-cycle MUL/DIV, flush, reset and single-cycle-latency sequences.
module tb_ula_control_mc;

  logic       clk = 1'b0;
  logic       reset, flush, valid_in;
  logic [9:0] inst;
  logic [2:0] ula_op;

  logic [4:0] sel_a, sel_n, sel_l;
  logic ill_a, start_a, div_a, stall_a, done_a, busy_a;
  logic ill_n, start_n, div_n, stall_n, done_n, busy_n;
  logic ill_l, start_l, div_l, stall_l, done_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_control_mc dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .inst(inst), .ula_op(ula_op), .ula_select(sel_a), .illegal(ill_a),
    .mdu_start(start_a), .mdu_is_div(div_a), .stall(stall_a),
    .mdu_done(done_a), .busy(busy_a)
  );

  ula_control_mc #(.ENABLE_M(0)) dut_nm (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .inst(inst), .ula_op(ula_op), .ula_select(sel_n), .illegal(ill_n),
    .mdu_start(start_n), .mdu_is_div(div_n), .stall(stall_n),
    .mdu_done(done_n), .busy(busy_n)
  );

  ula_control_mc #(.MUL_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .inst(inst), .ula_op(ula_op), .ula_select(sel_l), .illegal(ill_l),
    .mdu_start(start_l), .mdu_is_div(div_l), .stall(stall_l),
    .mdu_done(done_l), .busy(busy_l)
  );

  typedef struct {
    logic [2:0] op;
    logic [9:0] inst;
    logic       v;
    int         sel;
    int         ill;
    int         sel_n;
    int         ill_n;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] op, input logic [6:0] f7,
                     input logic [2:0] f3, input logic v, input int sel,
                     input int ill, input int seln, input int illn);
    vec_t r;
    r.op = op; r.inst = {f7, f3}; r.v = v;
    r.sel = sel; r.ill = ill; r.sel_n = seln; r.ill_n = illn;
    vecs.push_back(r);
  endtask

  task automatic rst_pulse();
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
    next();
    reset = 1'b0;
  endtask

  localparam logic [9:0] I_ADD  = 10'b0000000_000;
  localparam logic [9:0] I_MUL  = 10'b0000001_000;
  localparam logic [9:0] I_DIV  = 10'b0000001_100;
  localparam logic [9:0] I_DIVU = 10'b0000001_101;

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b1;
    inst = I_ADD; ula_op = 3'b000;
    #1;
    #4;
    chk("rst_sel", sel_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_ill", ill_a, 0);
    chk("rst_start", start_a, 0);
    next();
    reset = 1'b0; valid_in = 1'b0;
    #4;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    next();

    add(3'b000, 7'h7f, 3'b111, 1, 1, 0, 1, 0);
    add(3'b001, 7'h00, 3'b000, 1, 2, 0, 2, 0);
    add(3'b001, 7'h00, 3'b001, 1, 2, 0, 2, 0);
    add(3'b001, 7'h00, 3'b100, 1, 4, 0, 4, 0);
    add(3'b001, 7'h00, 3'b101, 1, 4, 0, 4, 0);
    add(3'b001, 7'h00, 3'b110, 1, 5, 0, 5, 0);
    add(3'b001, 7'h00, 3'b111, 1, 5, 0, 5, 0);
    add(3'b010, 7'h00, 3'b000, 1, 1, 0, 1, 0);
    add(3'b010, 7'h00, 3'b001, 1, 3, 0, 3, 0);
    add(3'b010, 7'h00, 3'b010, 1, 4, 0, 4, 0);
    add(3'b010, 7'h00, 3'b011, 1, 5, 0, 5, 0);
    add(3'b010, 7'h00, 3'b100, 1, 8, 0, 8, 0);
    add(3'b010, 7'h00, 3'b101, 1, 6, 0, 6, 0);
    add(3'b010, 7'h00, 3'b110, 1, 9, 0, 9, 0);
    add(3'b010, 7'h00, 3'b111, 1, 10, 0, 10, 0);
    add(3'b010, 7'h20, 3'b000, 1, 2, 0, 2, 0);
    add(3'b010, 7'h20, 3'b101, 1, 7, 0, 7, 0);
    add(3'b010, 7'h20, 3'b001, 1, 0, 1, 0, 1);
    add(3'b010, 7'h7f, 3'b000, 1, 0, 1, 0, 1);
    add(3'b010, 7'h01, 3'b000, 0, 13, 0, 0, 0);
    add(3'b010, 7'h01, 3'b011, 0, 16, 0, 0, 0);
    add(3'b010, 7'h01, 3'b111, 0, 20, 0, 0, 0);
    add(3'b011, 7'h7f, 3'b000, 1, 1, 0, 1, 0);
    add(3'b011, 7'h7f, 3'b010, 1, 4, 0, 4, 0);
    add(3'b011, 7'h7f, 3'b011, 1, 5, 0, 5, 0);
    add(3'b011, 7'h7f, 3'b100, 1, 8, 0, 8, 0);
    add(3'b011, 7'h7f, 3'b110, 1, 9, 0, 9, 0);
    add(3'b011, 7'h7f, 3'b111, 1, 10, 0, 10, 0);
    add(3'b011, 7'h00, 3'b001, 1, 3, 0, 3, 0);
    add(3'b011, 7'h20, 3'b001, 1, 0, 1, 0, 1);
    add(3'b011, 7'h00, 3'b101, 1, 6, 0, 6, 0);
    add(3'b011, 7'h20, 3'b101, 1, 7, 0, 7, 0);
    add(3'b011, 7'h01, 3'b101, 1, 0, 1, 0, 1);
    add(3'b100, 7'h00, 3'b000, 1, 11, 0, 11, 0);
    add(3'b101, 7'h00, 3'b000, 1, 12, 0, 12, 0);
    add(3'b110, 7'h00, 3'b000, 1, 0, 1, 0, 1);
    add(3'b111, 7'h00, 3'b000, 1, 0, 1, 0, 1);
    add(3'b110, 7'h00, 3'b000, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      ula_op = vecs[i].op; inst = vecs[i].inst; valid_in = vecs[i].v;
      #4;
      chk($sformatf("vec%0d_sel", i), sel_a, vecs[i].sel);
      chk($sformatf("vec%0d_ill", i), ill_a, vecs[i].ill);
      chk($sformatf("vec%0d_stall", i), stall_a, 0);
      chk($sformatf("vec%0d_start", i), start_a, 0);
      chk($sformatf("vec%0d_sel_nm", i), sel_n, vecs[i].sel_n);
      chk($sformatf("vec%0d_ill_nm", i), ill_n, vecs[i].ill_n);
      next();
    end

    // MUL, latency 3; inst changes while busy
    rst_pulse();
    ula_op = 3'b010; inst = I_MUL; valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) inst = I_ADD;
      #4;
      chk($sformatf("mul%0d_stall", k), stall_a, k < 3);
      chk($sformatf("mul%0d_start", k), start_a, k == 0);
      chk($sformatf("mul%0d_done", k), done_a, k == 3);
      chk($sformatf("mul%0d_busy", k), busy_a, k >= 1 && k <= 3);
      chk($sformatf("mul%0d_div", k), div_a, 0);
      chk($sformatf("mul%0d_sel", k), sel_a, k < 4 ? 13 : 1);
      if (k == 0) begin
        chk("nm_mul_ill", ill_n, 1);
        chk("nm_mul_sel", sel_n, 0);
        chk("nm_mul_stall", stall_n, 0);
      end
      next();
    end

    // DIVU, latency 34, then an ADD
    rst_pulse();
    ula_op = 3'b010; inst = I_DIVU; valid_in = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 1) inst = I_ADD;
      #4;
      chk($sformatf("divu%0d_stall", k), stall_a, k < 34);
      chk($sformatf("divu%0d_done", k), done_a, k == 34);
      chk($sformatf("divu%0d_isdiv", k), div_a, k <= 34);
      chk($sformatf("divu%0d_busy", k), busy_a, k >= 1 && k <= 34);
      chk($sformatf("divu%0d_sel", k), sel_a, k <= 34 ? 18 : 1);
      next();
    end

    // DIV flushed at T+10
    rst_pulse();
    ula_op = 3'b010; inst = I_DIV;
    for (int k = 0; k < 41; k++) begin
      valid_in = (k == 0);
      flush = (k == 10);
      #4;
      chk($sformatf("fl%0d_stall", k), stall_a, k < 10);
      chk($sformatf("fl%0d_done", k), done_a, 0);
      chk($sformatf("fl%0d_busy", k), busy_a, k >= 1 && k <= 10);
      next();
    end
    valid_in = 1'b1; flush = 1'b1;
    #4;
    chk("fl_idle_start", start_a, 0);
    chk("fl_idle_stall", stall_a, 0);
    next();
    valid_in = 1'b0; flush = 1'b0;
    #4;
    chk("fl_idle_busy", busy_a, 0);
    next();

    // DIV aborted by reset at T+5
    rst_pulse();
    ula_op = 3'b010; inst = I_DIV;
    for (int k = 0; k < 41; k++) begin
      valid_in = (k == 0) || (k == 5);
      reset = (k == 5);
      #4;
      chk($sformatf("rs%0d_stall", k), stall_a, k < 5);
      chk($sformatf("rs%0d_done", k), done_a, 0);
      chk($sformatf("rs%0d_busy", k), busy_a, k >= 1 && k <= 5);
      if (k == 5) begin
        chk("rs_sel", sel_a, 0);
        chk("rs_start", start_a, 0);
        chk("rs_ill", ill_a, 0);
      end
      next();
    end

    // MUL_LAT=1: back-to-back MULs
    rst_pulse();
    ula_op = 3'b010; inst = I_MUL; valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk($sformatf("l1_%0d_start", k), start_l, k == 0 || k == 2);
      chk($sformatf("l1_%0d_stall", k), stall_l, k == 0 || k == 2);
      chk($sformatf("l1_%0d_done", k), done_l, k == 1 || k == 3);
      chk($sformatf("l1_%0d_busy", k), busy_l, k == 1 || k == 3);
      chk($sformatf("l1_%0d_sel", k), sel_l, 13);
      next();
    end

    // MUL_LAT=1: flush in DONE hides mdu_done
    rst_pulse();
    ula_op = 3'b010; inst = I_MUL; valid_in = 1'b1;
    #4;
    chk("l1f_start", start_l, 1);
    next();
    valid_in = 1'b0; flush = 1'b1;
    #4;
    chk("l1f_done", done_l, 0);
    chk("l1f_busy", busy_l, 1);
    chk("l1f_stall", stall_l, 0);
    next();
    flush = 1'b0;
    #4;
    chk("l1f_idle", busy_l, 0);
    chk("l1f_done2", done_l, 0);
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
